// File: rtl/tag_alloc_arbiter.sv
// -----------------------------------------------------------------------------
// tag_alloc_arbiter
//
// Hands out tags from an external first-word-fall-through tag FIFO to four
// requesters in round-robin order, and recycles tags returned by the ROB back
// into that FIFO. After reset the block first fills the FIFO with tags
// 0..NTAGS-1 (INIT), then serves requests (RUN). A flush from the ROB stops
// allocation until every outstanding tag has been returned (FLUSH).
//
// Ports
//   clock, reset    : single clock, synchronous active-high reset
//   req[3:0]        : per-requester level request
//   flush           : pipeline flush pulse
//   commit_tag/valid: tag returned by the ROB
//   Tag_Out         : tag FIFO head (FWFT), valid when !tagFifo_empty
//   tagFifo_empty   : tag FIFO empty flag
//   tagFifo_full    : tag FIFO full flag
//   Rd_en           : pop strobe to the tag FIFO
//   RB_Tag/_Valid   : write data / strobe to the tag FIFO
//   gnt_valid       : one-cycle grant pulse, the cycle after the pop
//   gnt_id, gnt_tag : granted requester and its tag (hold between grants)
//   alloc_ready     : high while in RUN
//   outstanding     : allocated, not-yet-returned tag count
//   proto_err       : sticky protocol-error flag
// -----------------------------------------------------------------------------
module tag_alloc_arbiter #(
    parameter int TAGW  = 5,
    parameter int NTAGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic            flush,
    input  logic [TAGW-1:0] commit_tag,
    input  logic            commit_valid,
    input  logic [TAGW-1:0] Tag_Out,
    input  logic            tagFifo_empty,
    input  logic            tagFifo_full,
    output logic            Rd_en,
    output logic [TAGW-1:0] RB_Tag,
    output logic            RB_Tag_Valid,
    output logic            gnt_valid,
    output logic [1:0]      gnt_id,
    output logic [TAGW-1:0] gnt_tag,
    output logic            alloc_ready,
    output logic [TAGW:0]   outstanding,
    output logic            proto_err
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam logic [TAGW-1:0] LAST_TAG = TAGW'(NTAGS - 1);
    localparam logic [TAGW-1:0] TAG_ONE  = TAGW'(1);
    localparam logic [TAGW:0]   OUT_ONE  = (TAGW + 1)'(1);
    localparam logic [TAGW:0]   OUT_ZERO = '0;

    state_t          r_state;
    state_t          w_state_next;
    logic [TAGW-1:0] r_init_cnt;
    logic [1:0]      r_rr;
    logic [TAGW:0]   r_outstanding;
    logic            r_gnt_valid;
    logic [1:0]      r_gnt_id;
    logic [TAGW-1:0] r_gnt_tag;
    logic            r_proto_err;

    logic [1:0]      w_cand_idx [4];
    logic [3:0]      w_cand_req;
    logic [1:0]      w_winner;
    logic            w_pop;
    logic            w_commit_err;
    logic            w_commit_ok;

    // Candidate gi is the requester gi places after the round-robin pointer;
    // the 2-bit add wraps modulo 4 on its own.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand_idx[gi] = r_rr + 2'(gi);
            assign w_cand_req[gi] = req[w_cand_idx[gi]];
        end
    endgenerate

    // Lowest-offset active candidate wins.
    always_comb begin
        w_winner = r_rr;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                w_winner = w_cand_idx[k];
            end
        end
    end

    always_comb begin
        Rd_en        = 1'b0;
        RB_Tag       = commit_tag;
        RB_Tag_Valid = commit_valid;
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                RB_Tag       = r_init_cnt;
                RB_Tag_Valid = 1'b1;
                if (r_init_cnt == LAST_TAG) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                Rd_en = (|req) & ~tagFifo_empty & ~flush;
                if (flush) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_outstanding == OUT_ZERO) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_pop = Rd_en;

    // A same-cycle pop makes a commit at outstanding==0 legitimate: the
    // returned tag can be the one just handed out.
    assign w_commit_err = commit_valid &
                          ((r_state == ST_INIT) | tagFifo_full |
                           ((r_outstanding == OUT_ZERO) & ~w_pop));
    assign w_commit_ok  = commit_valid & ~w_commit_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            r_rr          <= '0;
            r_outstanding <= '0;
            r_gnt_valid   <= 1'b0;
            r_gnt_id      <= '0;
            r_gnt_tag     <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + TAG_ONE;
            end
            case ({w_pop, w_commit_ok})
                2'b10:   r_outstanding <= r_outstanding + OUT_ONE;
                2'b01:   r_outstanding <= r_outstanding - OUT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
            r_gnt_valid <= w_pop;
            if (w_pop) begin
                r_gnt_id  <= w_winner;
                r_gnt_tag <= Tag_Out;
                r_rr      <= w_winner + 2'd1;
            end
            if (w_commit_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign gnt_valid   = r_gnt_valid;
    assign gnt_id      = r_gnt_id;
    assign gnt_tag     = r_gnt_tag;
    assign alloc_ready = (r_state == ST_RUN);
    assign outstanding = r_outstanding;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_tag_alloc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tag_alloc_arbiter
//
// Bench for tag_alloc_arbiter. Contains a FWFT tag FIFO for the environment,
// a requester/ROB agent, and a reference model that tracks the free-tag list,
// outstanding count, round-robin pointer and phase from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_tag_alloc_arbiter;

    localparam int TAGW  = 5;
    localparam int NTAGS = 32;
    localparam int PH_INIT  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_FLUSH = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic            flush;
    logic [TAGW-1:0] commit_tag;
    logic            commit_valid;
    logic [TAGW-1:0] tag_out_q;
    logic            fifo_empty_q;
    logic            fifo_full_q;
    logic            Rd_en;
    logic [TAGW-1:0] RB_Tag;
    logic            RB_Tag_Valid;
    logic            gnt_valid;
    logic [1:0]      gnt_id;
    logic [TAGW-1:0] gnt_tag;
    logic            alloc_ready;
    logic [TAGW:0]   outstanding;
    logic            proto_err;

    tag_alloc_arbiter #(.TAGW(TAGW), .NTAGS(NTAGS)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .flush        (flush),
        .commit_tag   (commit_tag),
        .commit_valid (commit_valid),
        .Tag_Out      (tag_out_q),
        .tagFifo_empty(fifo_empty_q),
        .tagFifo_full (fifo_full_q),
        .Rd_en        (Rd_en),
        .RB_Tag       (RB_Tag),
        .RB_Tag_Valid (RB_Tag_Valid),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .gnt_tag      (gnt_tag),
        .alloc_ready  (alloc_ready),
        .outstanding  (outstanding),
        .proto_err    (proto_err)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // drive values applied at the next negedge
    logic            d_reset;
    logic [3:0]      d_req;
    logic            d_flush;
    logic            d_cv;
    logic [TAGW-1:0] d_ct;

    // environment FIFO
    logic [TAGW-1:0] env_q[$];

    // reference model
    int              m_phase;
    int              m_init_idx;
    int              m_rr;
    int              m_out;
    bit              m_err;
    bit              m_gv;
    int              m_gid;
    logic [TAGW-1:0] m_gtag;
    logic [TAGW-1:0] m_tags[$];

    // agent state
    logic [TAGW-1:0] alloc_q[$];
    logic [3:0]      hold;
    int              gnt_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = PH_INIT;
        m_init_idx = 0;
        m_rr       = 0;
        m_out      = 0;
        m_err      = 0;
        m_gv       = 0;
        m_gid      = 0;
        m_gtag     = '0;
        m_tags.delete();
        alloc_q.delete();
        hold = '0;
    endtask

    task automatic run_cycle();
        bit              e_rd, e_rbv, full_before, legal, cap_rd, cap_rbv, cap_full;
        logic [TAGW-1:0] e_rbt, cap_rbt;
        int              w, old_out;
        @(negedge clock);
        reset        = d_reset;
        req          = d_req;
        flush        = d_flush;
        commit_valid = d_cv;
        commit_tag   = d_ct;
        #1;
        e_rd  = 0;
        e_rbv = 0;
        e_rbt = '0;
        if (!d_reset) begin
            if (m_phase == PH_INIT) begin
                e_rbv = 1;
                e_rbt = TAGW'(m_init_idx);
            end else begin
                e_rbv = d_cv;
                e_rbt = d_ct;
                e_rd  = (m_phase == PH_RUN) && (d_req != 0) && (m_tags.size() > 0) && !d_flush;
            end
            check_val("rd_en", 32'(Rd_en), 32'(e_rd));
            check_val("rb_valid", 32'(RB_Tag_Valid), 32'(e_rbv));
            if (e_rbv) check_val("rb_tag", 32'(RB_Tag), 32'(e_rbt));
        end
        cap_rd   = Rd_en;
        cap_rbv  = RB_Tag_Valid;
        cap_rbt  = RB_Tag;
        cap_full = fifo_full_q;
        // model step
        if (d_reset) begin
            model_reset();
        end else begin
            full_before = (m_tags.size() >= NTAGS);
            if (m_phase == PH_INIT) begin
                if (d_cv) m_err = 1;
                m_gv = 0;
                m_init_idx++;
                if (m_init_idx == NTAGS) m_phase = PH_RUN;
            end else begin
                w = m_rr;
                for (int k = 0; k < 4; k++) begin
                    if (d_req[(m_rr + k) % 4]) begin
                        w = (m_rr + k) % 4;
                        break;
                    end
                end
                legal = d_cv && !full_before && !(m_out == 0 && !e_rd);
                if (d_cv && !legal) m_err = 1;
                old_out = m_out;
                m_out = m_out + int'(e_rd) - int'(legal);
                m_gv = e_rd;
                if (e_rd) begin
                    m_gid  = w;
                    m_gtag = m_tags.pop_front();
                    m_rr   = (w + 1) % 4;
                end
                if (m_phase == PH_RUN && d_flush) m_phase = PH_FLUSH;
                else if (m_phase == PH_FLUSH && old_out == 0) m_phase = PH_RUN;
            end
            if (e_rbv && !full_before) m_tags.push_back(e_rbt);
        end
        @(posedge clock);
        #1;
        // environment FIFO reacts to the strobes the DUT actually drove
        if (d_reset) begin
            env_q.delete();
        end else begin
            if (cap_rd && env_q.size() > 0) void'(env_q.pop_front());
            if (cap_rbv && !cap_full) env_q.push_back(cap_rbt);
        end
        fifo_empty_q = (env_q.size() == 0);
        fifo_full_q  = (env_q.size() >= NTAGS);
        tag_out_q    = (env_q.size() > 0) ? env_q[0] : '0;
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_gv));
        check_val("gnt_id", 32'(gnt_id), 32'(m_gid));
        check_val("gnt_tag", 32'(gnt_tag), 32'(m_gtag));
        check_val("alloc_ready", 32'(alloc_ready), 32'(m_phase == PH_RUN));
        check_val("outstanding", 32'(outstanding), 32'(m_out));
        check_val("proto_err", 32'(proto_err), 32'(m_err));
        if (m_gv) begin
            $display("grant id=%0d tag=%0d outstanding=%0d", m_gid, m_gtag, m_out);
            alloc_q.push_back(m_gtag);
            hold[m_gid] = 1'b0;
            gnt_seen++;
        end
    endtask

    task automatic idle_inputs();
        d_reset = 0;
        d_req   = '0;
        d_flush = 0;
        d_cv    = 0;
        d_ct    = '0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        d_reset = 1;
        for (int i = 0; i < n; i++) run_cycle();
        d_reset = 0;
    endtask

    task automatic commit_front();
        d_cv = 0;
        if (alloc_q.size() > 0) begin
            d_ct = alloc_q.pop_front();
            d_cv = 1;
        end
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 4 * NTAGS && alloc_q.size() > 0; i++) begin
            commit_front();
            run_cycle();
        end
        idle_inputs();
        run_cycle();
    endtask

    task automatic agent_drive(input int p_req, input int p_commit, input int p_flush);
        int pc, idx;
        for (int i = 0; i < 4; i++) begin
            if (!hold[i] && ($urandom % 100) < p_req) hold[i] = 1'b1;
        end
        d_req = hold;
        pc = (m_phase == PH_FLUSH) ? 90 : p_commit;
        d_cv = 0;
        if (alloc_q.size() > 0 && ($urandom % 100) < pc) begin
            idx  = $urandom_range(0, alloc_q.size() - 1);
            d_ct = alloc_q[idx];
            alloc_q.delete(idx);
            d_cv = 1;
        end
        d_flush = (m_phase == PH_RUN) && (($urandom % 100) < p_flush);
    endtask

    initial begin
        int gcount;
        logic [TAGW-1:0] ctag;
        reset = 1; req = '0; flush = 0; commit_valid = 0; commit_tag = '0;
        tag_out_q = '0; fifo_empty_q = 1; fifo_full_q = 0;
        gnt_seen = 0;
        model_reset();

        // reset and INIT fill
        do_reset(2);
        for (int i = 0; i < NTAGS; i++) run_cycle();
        check_val("init_ready", 32'(alloc_ready), 32'd1);
        check_val("init_full", 32'(fifo_full_q), 32'd1);

        // req=1111 for 8 cycles: round-robin ids and tags 0..7
        gcount = gnt_seen;
        for (int k = 0; k < 8; k++) begin
            d_req = 4'b1111;
            run_cycle();
            check_val("rr8_id", 32'(gnt_id), 32'(k % 4));
            check_val("rr8_tag", 32'(gnt_tag), 32'(k));
        end
        check_val("rr8_out", 32'(outstanding), 32'd8);

        // keep requesting: FIFO runs dry after 32 grants
        for (int k = 0; k < 32; k++) run_cycle();
        check_val("dry_grants", 32'(gnt_seen - gcount), 32'd32);
        check_val("dry_out", 32'(outstanding), 32'd32);
        check_val("dry_empty", 32'(fifo_empty_q), 32'd1);
        check_val("dry_rd", 32'(Rd_en), 32'd0);
        check_val("dry_err", 32'(proto_err), 32'd0);
        drain();

        // pop and commit in the same cycle at outstanding=5
        for (int k = 0; k < 5; k++) begin
            d_req = 4'b1111;
            run_cycle();
        end
        d_req = 4'b1111;
        commit_front();
        ctag = d_ct;
        run_cycle();
        check_val("same_out", 32'(outstanding), 32'd5);
        check_val("same_wr", 32'(env_q[env_q.size() - 1]), 32'(ctag));

        // flush with outstanding=3, then three returns
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            commit_front();
            run_cycle();
        end
        check_val("fl_out3", 32'(outstanding), 32'd3);
        gcount = gnt_seen;
        idle_inputs();
        d_req = 4'b1111;
        d_flush = 1;
        run_cycle();
        d_flush = 0;
        for (int k = 0; k < 3; k++) begin
            commit_front();
            run_cycle();
        end
        d_cv = 0;
        check_val("fl_wait", 32'(alloc_ready), 32'd0);
        run_cycle();
        check_val("fl_run", 32'(alloc_ready), 32'd1);
        check_val("fl_nognt", 32'(gnt_seen - gcount), 32'd0);
        drain();

        // randomized traffic with occasional flushes
        for (int k = 0; k < 800; k++) begin
            agent_drive(30, 25, 3);
            run_cycle();
        end

        // reset in the middle of activity
        d_req = 4'b1111;
        d_cv  = (alloc_q.size() > 0);
        d_ct  = (alloc_q.size() > 0) ? alloc_q[0] : '0;
        d_reset = 1;
        run_cycle();
        run_cycle();
        idle_inputs();
        check_val("mid_rst_out", 32'(outstanding), 32'd0);
        for (int i = 0; i < NTAGS; i++) run_cycle();
        for (int k = 0; k < 150; k++) begin
            agent_drive(40, 30, 2);
            run_cycle();
        end
        idle_inputs();
        drain();

        // commit with nothing outstanding sets the sticky error
        d_cv = 1;
        d_ct = 5'd3;
        run_cycle();
        idle_inputs();
        check_val("err_zero", 32'(proto_err), 32'd1);
        for (int k = 0; k < 3; k++) run_cycle();
        check_val("err_sticky", 32'(proto_err), 32'd1);

        // reset clears it; commit during INIT sets it again
        do_reset(2);
        check_val("err_clr", 32'(proto_err), 32'd0);
        for (int k = 0; k < 4; k++) run_cycle();
        d_cv = 1;
        d_ct = 5'd9;
        run_cycle();
        idle_inputs();
        check_val("err_init", 32'(proto_err), 32'd1);
        for (int i = 0; i < NTAGS; i++) run_cycle();
        check_val("err_init_sticky", 32'(proto_err), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tag_alloc_arbiter.md
TAG_ALLOC_ARBITER -- requirements
Module: tag_alloc_arbiter

Interface
REQ-001 SHALL have parameter TAGW, default 5, tag width in bits.
REQ-002 SHALL have parameter NTAGS, default 32, tag count loaded into the tag FIFO (2**TAGW).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester tag request, level; bit i = requester i.
REQ-006 SHALL have port flush  input  1  pipeline flush pulse from the ROB.
REQ-007 SHALL have port commit_tag  input  TAGW  tag being retired or squashed by the ROB.
REQ-008 SHALL have port commit_valid  input  1  qualifies commit_tag.
REQ-009 SHALL have port Tag_Out  input  TAGW  tag FIFO head, first-word-fall-through, valid when !tagFifo_empty.
REQ-010 SHALL have port tagFifo_empty  input  1  tag FIFO empty flag.
REQ-011 SHALL have port tagFifo_full  input  1  tag FIFO full flag.
REQ-012 SHALL have port Rd_en  output  1  pop strobe to the tag FIFO.
REQ-013 SHALL have port RB_Tag  output  TAGW  tag written into the tag FIFO.
REQ-014 SHALL have port RB_Tag_Valid  output  1  write strobe to the tag FIFO.
REQ-015 SHALL have port gnt_valid  output  1  registered one-cycle grant pulse.
REQ-016 SHALL have port gnt_id  output  2  index of granted requester.
REQ-017 SHALL have port gnt_tag  output  TAGW  tag allocated to gnt_id.
REQ-018 SHALL have port alloc_ready  output  1  high only in state RUN.
REQ-019 SHALL have port outstanding  output  TAGW+1  count of allocated, not-yet-returned tags (0..NTAGS).
REQ-020 SHALL have port proto_err  output  1  sticky protocol-error flag.

Function
REQ-021 SHALL implement states INIT, RUN, FLUSH.
REQ-022 INIT: SHALL drive RB_Tag_Valid=1 with RB_Tag = init counter 0..NTAGS-1, one per cycle, then enter RUN the cycle after tag NTAGS-1 is written; no grants; Rd_en=0.
REQ-023 RUN/FLUSH: RB_Tag=commit_tag, RB_Tag_Valid=commit_valid, combinationally.
REQ-024 RUN: Rd_en SHALL equal (|req) & !tagFifo_empty & !flush, combinationally.
REQ-025 Winner SHALL be chosen round-robin: search starts at pointer rr (reset 0), ascending mod 4; on a pop, rr <= winner+1 mod 4; no pop leaves rr unchanged.
REQ-026 On a pop, next cycle gnt_valid=1, gnt_id=winner, gnt_tag=Tag_Out sampled at the pop edge; otherwise gnt_valid=0, gnt_id/gnt_tag hold.
REQ-027 At most one grant per cycle; a requester keeps req high until it sees its gnt.
REQ-028 outstanding: +1 on pop, -1 on commit_valid, unchanged if both in same cycle.
REQ-029 flush in RUN: no pop that cycle; next state FLUSH.
REQ-030 FLUSH: Rd_en=0; stay until outstanding==0 (ROB returns squashed tags via commit path); then RUN next cycle; flush in FLUSH is ignored.
REQ-031 tagFifo_empty in RUN: Rd_en=0, requests stall, no error.
REQ-032 proto_err SHALL set on: commit_valid in INIT; commit_valid with outstanding==0 and no pop that cycle; commit_valid while tagFifo_full; cleared only by reset. Erroneous commit SHALL not change outstanding.

Reset
REQ-033 On reset: state=INIT, init counter=0, rr=0, outstanding=0, gnt_valid=0, gnt_id=0, gnt_tag=0, proto_err=0, alloc_ready=0.
REQ-034 Reset asserted mid-operation SHALL override all activity that edge and restart INIT; the tag FIFO is reset by the same reset.

Verification
REQ-035 Reset, idle -> RB_Tag_Valid high 32 cycles with RB_Tag 0..31, then alloc_ready=1, tagFifo_full=1.
REQ-036 req=4'b1111 held 8 cycles after INIT -> gnt_id 0,1,2,3,0,1,2,3, gnt_tag 0..7, outstanding=8.
REQ-037 req=4'b1111 held 40 cycles -> 32 grants, then Rd_en=0 with tagFifo_empty=1, outstanding=32, proto_err=0.
REQ-038 Pop and commit_valid same cycle with outstanding=5 -> outstanding stays 5, commit_tag written to FIFO.
REQ-039 flush with outstanding=3, then 3 commits -> no grants during FLUSH, RUN the cycle after outstanding reaches 0.
REQ-040 commit_valid in INIT, or with outstanding=0 -> proto_err=1 and stays 1 until reset.
